// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard / stall-flush control.
// Imported by the interface, the mul/div sequencer and the hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_W       = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 6;
  localparam int PERF_W_DEF  = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
  } hz_ctrl_t;

  // Hazard priority, shared with the forwarding unit:
  //   1. taken branch squashes ID, so it wins over every stall
  //   2. load-use / HI-LO hazards freeze PC and IF/ID and bubble EX
  //   3. otherwise the pipeline runs; forwarding covers ALU RAW hazards
  localparam hz_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b1, ifid_flush: 1'b1};
  localparam hz_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b0};
  localparam hz_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard inputs and stall/flush outputs between the pipeline and the
// hazard controller.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int PERF_W = PERF_W_DEF
);
  logic             IDEX_MemRead;
  logic [REG_W-1:0] IDEX_RegisterRt;
  logic [REG_W-1:0] IFID_RegisterRs;
  logic [REG_W-1:0] IFID_RegisterRt;
  logic             IFID_UsesRt;
  logic             IFID_ReadsHiLo;
  logic             IFID_IsMulDiv;
  logic             branch_taken;
  logic             md_start;
  logic             md_div;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             md_busy;
  logic             md_done;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
           IFID_UsesRt, IFID_ReadsHiLo, IFID_IsMulDiv, branch_taken, md_start, md_div,
    input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, md_busy, md_done, stall_cycles
  );

  modport slave (
    input  IDEX_MemRead, IDEX_RegisterRt, IFID_RegisterRs, IFID_RegisterRt,
           IFID_UsesRt, IFID_ReadsHiLo, IFID_IsMulDiv, branch_taken, md_start, md_div,
    output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, md_busy, md_done, stall_cycles
  );
endinterface

// File: rtl/muldiv_seq.sv
// Mul/div occupancy sequencer: tracks one in-flight op with a latency
// down-counter; busy/done decode from registered state only.
module muldiv_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  input  logic kill,
  output logic md_busy,
  output logic md_done
);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start in the same EX slot as a taken branch is squashed, never issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          state_d = MD_BUSY;
          cnt_d   = div ? DIV_LD : MUL_LD;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);
  assign md_done = md_busy && (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use and HI/LO hazard detection, branch flush,
// mul/div occupancy and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PERF_W  = PERF_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  logic              load_use, md_haz, md_busy, md_done;
  hz_ctrl_t          ctrl;
  logic [PERF_W-1:0] perf_q;

  muldiv_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (hz.md_start),
    .div     (hz.md_div),
    .kill    (hz.branch_taken),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_RegisterRt != '0) &&
                    ((hz.IDEX_RegisterRt == hz.IFID_RegisterRs) ||
                     (hz.IFID_UsesRt && (hz.IDEX_RegisterRt == hz.IFID_RegisterRt)));
  assign md_haz   = md_busy && (hz.IFID_ReadsHiLo || hz.IFID_IsMulDiv);

  always_comb begin
    ctrl = CTRL_RUN;
    if (hz.branch_taken)         ctrl = CTRL_FLUSH;
    else if (md_haz || load_use) ctrl = CTRL_STALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             perf_q <= '0;
    else if (!ctrl.pc_write && perf_q != '1) perf_q <= perf_q + 1'b1;
  end

  assign hz.PCWrite      = ctrl.pc_write;
  assign hz.IFIDWrite    = ctrl.ifid_write;
  assign hz.IDEX_Bubble  = ctrl.idex_bubble;
  assign hz.IFID_Flush   = ctrl.ifid_flush;
  assign hz.md_busy      = md_busy;
  assign hz.md_done      = md_done;
  assign hz.stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: decode vector table, hand-written mul/div,
// reset, branch and saturation sequences, then random traffic vs a model.
module tb_pipe_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int PERF_W  = 4;
  localparam int PMAX    = (1 << PERF_W) - 1;

  typedef struct packed {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       hilo;
    logic       ismd;
    logic       br;
    logic       start;
    logic       div;
  } stim_t;

  typedef struct {
    stim_t      in;
    logic [3:0] exp; // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.PERF_W(PERF_W)) hif ();

  pipe_hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6),
    .PERF_W  (PERF_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: remaining busy cycles of the in-flight op, stall count.
  int    busy_left = 0;
  int    perf = 0;
  stim_t cur;
  stim_t idle_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t mk(input bit memread, input int ex_rt, input int rs, input int rt,
                               input bit uses_rt, input bit hilo, input bit ismd, input bit br,
                               input bit start, input bit div);
    stim_t s;
    s.memread = memread; s.ex_rt = 5'(ex_rt); s.rs = 5'(rs); s.rt = 5'(rt);
    s.uses_rt = uses_rt; s.hilo = hilo; s.ismd = ismd; s.br = br;
    s.start = start; s.div = div;
    return s;
  endfunction

  function automatic logic [3:0] model_ctrl(input stim_t s);
    bit lu, mh;
    lu = s.memread && s.ex_rt != 0 && (s.ex_rt == s.rs || (s.uses_rt && s.ex_rt == s.rt));
    mh = (busy_left > 0) && (s.hilo || s.ismd);
    if (s.br)          return 4'b1111;
    else if (lu || mh) return 4'b0010;
    else               return 4'b1100;
  endfunction

  task automatic drive(input stim_t s);
    cur = s;
    hif.IDEX_MemRead    = s.memread;
    hif.IDEX_RegisterRt = s.ex_rt;
    hif.IFID_RegisterRs = s.rs;
    hif.IFID_RegisterRt = s.rt;
    hif.IFID_UsesRt     = s.uses_rt;
    hif.IFID_ReadsHiLo  = s.hilo;
    hif.IFID_IsMulDiv   = s.ismd;
    hif.branch_taken    = s.br;
    hif.md_start        = s.start;
    hif.md_div          = s.div;
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    drive(s);
    #1;
  endtask

  task automatic check_model();
    logic [3:0] e;
    e = model_ctrl(cur);
    chk("PCWrite",      32'(hif.PCWrite),      32'(e[3]));
    chk("IFIDWrite",    32'(hif.IFIDWrite),    32'(e[2]));
    chk("IDEX_Bubble",  32'(hif.IDEX_Bubble),  32'(e[1]));
    chk("IFID_Flush",   32'(hif.IFID_Flush),   32'(e[0]));
    chk("md_busy",      32'(hif.md_busy),      32'(busy_left > 0));
    chk("md_done",      32'(hif.md_done),      32'(busy_left == 1));
    chk("stall_cycles", 32'(hif.stall_cycles), 32'(perf));
  endtask

  task automatic advance();
    logic [3:0] e;
    e = model_ctrl(cur);
    @(posedge clk);
    if (!e[3] && perf < PMAX) perf++;
    if (busy_left > 0)                busy_left--;
    else if (cur.start && !cur.br)    busy_left = cur.div ? DIV_LAT : MUL_LAT;
  endtask

  task automatic step(input stim_t s);
    apply(s);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    busy_left = 0;
    perf = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    idle_s = '0;
    drive(idle_s);

    // memread ex_rt rs rt uses_rt hilo ismd br start div
    vecs.push_back('{mk(1, 5, 5, 0, 0, 0, 0, 0, 0, 0), 4'b0010}); // load-use on rs
    vecs.push_back('{mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0), 4'b1100}); // $zero never stalls
    vecs.push_back('{mk(1, 5, 3, 5, 0, 0, 0, 0, 0, 0), 4'b1100}); // rt match but unused
    vecs.push_back('{mk(1, 5, 3, 5, 1, 0, 0, 0, 0, 0), 4'b0010}); // load-use on rt
    vecs.push_back('{mk(0, 5, 5, 5, 1, 0, 0, 0, 0, 0), 4'b1100}); // not a load
    vecs.push_back('{mk(1, 5, 5, 0, 0, 0, 0, 1, 0, 0), 4'b1111}); // branch over load-use
    vecs.push_back('{mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 4'b1100}); // HI/LO read, unit idle
    vecs.push_back('{mk(1, 31, 31, 2, 0, 0, 0, 0, 0, 0), 4'b0010});
    vecs.push_back('{mk(1, 7, 6, 8, 1, 0, 0, 0, 0, 0), 4'b1100});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 4'b1111}); // plain branch

    // reset state
    #1;
    chk("rst md_busy", 32'(hif.md_busy), 0);
    chk("rst md_done", 32'(hif.md_done), 0);
    chk("rst stall_cycles", 32'(hif.stall_cycles), 0);
    chk("rst PCWrite", 32'(hif.PCWrite), 1);
    chk("rst IDEX_Bubble", 32'(hif.IDEX_Bubble), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // decode table
    foreach (vecs[i]) begin
      apply(vecs[i].in);
      chk($sformatf("vec%0d PCWrite", i),     32'(hif.PCWrite),     32'(vecs[i].exp[3]));
      chk($sformatf("vec%0d IFIDWrite", i),   32'(hif.IFIDWrite),   32'(vecs[i].exp[2]));
      chk($sformatf("vec%0d IDEX_Bubble", i), 32'(hif.IDEX_Bubble), 32'(vecs[i].exp[1]));
      chk($sformatf("vec%0d IFID_Flush", i),  32'(hif.IFID_Flush),  32'(vecs[i].exp[0]));
      advance();
    end
    step(idle_s);

    // multiply: start at cycle 10, HI/LO reader from cycle 11
    do_reset();
    for (int c = 0; c < 10; c++) step(idle_s);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int c = 11; c <= 15; c++) begin
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      check_model();
      chk($sformatf("mul c%0d md_busy", c), 32'(hif.md_busy), 32'(c <= 14));
      chk($sformatf("mul c%0d md_done", c), 32'(hif.md_done), 32'(c == 14));
      chk($sformatf("mul c%0d PCWrite", c), 32'(hif.PCWrite), 32'(c == 15));
      if (c == 15) chk("mul stall_cycles", 32'(hif.stall_cycles), 4);
      advance();
    end

    // divide: start at cycle 0, independent instructions never stall
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int c = 1; c <= 34; c++) begin
      apply(mk(0, 0, 9, 10, 1, 0, 0, 0, 0, 0));
      check_model();
      chk($sformatf("div c%0d md_done", c), 32'(hif.md_done), 32'(c == 32));
      chk($sformatf("div c%0d PCWrite", c), 32'(hif.PCWrite), 1);
      advance();
    end

    // reset mid-divide at cnt=20 (12 cycles after issue)
    do_reset();
    step(mk(1, 4, 4, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int c = 1; c < 12; c++) step(idle_s);
    apply(idle_s);
    chk("pre-rst md_busy", 32'(hif.md_busy), 1);
    rst_n = 1'b0;
    busy_left = 0;
    perf = 0;
    #1;
    chk("midrst md_busy", 32'(hif.md_busy), 0);
    chk("midrst stall_cycles", 32'(hif.stall_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(idle_s);
    chk("postrst PCWrite", 32'(hif.PCWrite), 1);
    chk("postrst IDEX_Bubble", 32'(hif.IDEX_Bubble), 0);
    check_model();
    advance();

    // branch priority during mul with md_haz and load_use; start killed by branch
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    apply(mk(1, 6, 6, 0, 0, 1, 1, 1, 0, 0));
    chk("br PCWrite", 32'(hif.PCWrite), 1);
    chk("br IFID_Flush", 32'(hif.IFID_Flush), 1);
    chk("br IDEX_Bubble", 32'(hif.IDEX_Bubble), 1);
    check_model();
    advance();
    for (int c = 2; c <= 5; c++) begin
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      check_model();
      chk($sformatf("br c%0d md_done", c), 32'(hif.md_done), 32'(c == 4));
      advance();
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    apply(idle_s);
    chk("killed start md_busy", 32'(hif.md_busy), 0);
    check_model();
    advance();

    // saturation: 20 consecutive load-use stalls
    do_reset();
    for (int c = 0; c < 20; c++) step(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0));
    apply(idle_s);
    chk("sat stall_cycles", 32'(hif.stall_cycles), 15);
    advance();

    // random traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stim_t s;
      s.memread = 1'($urandom_range(0, 1));
      s.ex_rt   = 5'($urandom_range(0, 3));
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom_range(0, 1));
      s.hilo    = ($urandom_range(0, 3) == 0);
      s.ismd    = ($urandom_range(0, 5) == 0);
      s.br      = ($urandom_range(0, 7) == 0);
      s.start   = ($urandom_range(0, 5) == 0);
      s.div     = ($urandom_range(0, 3) == 0);
      step(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
